// File: rtl/lc3b_decode_seq_pkg.sv
// Shared types for the LC-3b decode stage: opcodes, ALU ops, sequencer
// states and the control word handed to execute.
// Optional feature macro: LC3B_INDIRECT_EN (LDI/STI become two micro-ops).
package lc3b_decode_seq_pkg;

    localparam int unsigned CTRL_PC_W = 16;

    typedef enum logic [3:0] {
        OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB = 4'h3,
        OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
        OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
        OP_JMP = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add, alu_and, alu_not, alu_passa, alu_passb, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;

    typedef enum logic {
        IDLE = 1'b0,
        IND2 = 1'b1
    } lc3b_decode_state_t;

    typedef struct packed {
        logic [CTRL_PC_W-1:0] pc;
        lc3b_aluop            aluop;
        logic                 load_reg;
        logic                 load_cc;
        logic [1:0]           wbmux_sel;
        logic                 sr2mux_sel;
        logic                 addr1mux_sel;
        logic [1:0]           addr2mux_sel;
        logic                 lshf;
        logic                 storemux_sel;
        logic                 br_op;
        logic                 dcacheR;
        logic                 dcacheW;
        logic                 dcache_enable;
        logic                 uop;
        logic                 illegal;
    } lc3b_control_word;

    // One bit per opcode; set means this build cannot decode it.
`ifdef LC3B_INDIRECT_EN
    localparam logic [15:0] OP_ILLEGAL_MASK = 16'hF11C;
`else
    localparam logic [15:0] OP_ILLEGAL_MASK = 16'hFD1C;
`endif

    localparam logic UOP_IND2 = 1'b1;

    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/lc3b_decode_seq_if.sv
// Fetch -> decode -> execute handshake bundle.
// master: fetch/downstream side (drives in_*, stall, flush).
// slave : decode stage (drives in_ready and out_*).
interface lc3b_decode_seq_if
    import lc3b_decode_seq_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) ();
    logic              in_valid;
    logic [WORD_W-1:0] in_ir;
    logic [WORD_W-1:0] in_pc;
    logic              in_ready;
    logic              stall;
    logic              flush;
    logic              out_valid;
    lc3b_control_word  out_ctrl;
    logic [WORD_W-1:0] out_ir;
    logic [WORD_W-1:0] out_pc;
    logic              out_uop;
    logic              out_illegal;

    modport master (
        output in_valid, in_ir, in_pc, stall, flush,
        input  in_ready, out_valid, out_ctrl, out_ir, out_pc, out_uop, out_illegal
    );

    modport slave (
        input  in_valid, in_ir, in_pc, stall, flush,
        output in_ready, out_valid, out_ctrl, out_ir, out_pc, out_uop, out_illegal
    );
endinterface

// File: rtl/lc3b_decode_comb.sv
// Pure combinational control-word table.
// Ports: opcode, ir5, uop (micro-op index) in; ctrl_c (pc field left 0) out.
// Macro LC3B_INDIRECT_EN enables the LDI/STI rows.
module lc3b_decode_comb
    import lc3b_decode_seq_pkg::*;
(
    input  lc3b_opcode       opcode,
    input  logic             ir5,
    input  logic             uop,
    output lc3b_control_word ctrl_c
);

    always_comb begin
        ctrl_c       = '0;
        ctrl_c.aluop = alu_passa;
        ctrl_c.uop   = uop;
        case (opcode)
            OP_ADD, OP_AND: begin
                ctrl_c.aluop      = (opcode == OP_ADD) ? alu_add : alu_and;
                ctrl_c.load_reg   = 1'b1;
                ctrl_c.load_cc    = 1'b1;
                ctrl_c.wbmux_sel  = 2'b11;
                ctrl_c.sr2mux_sel = ir5;
            end
            OP_NOT: begin
                ctrl_c.aluop     = alu_not;
                ctrl_c.load_reg  = 1'b1;
                ctrl_c.load_cc   = 1'b1;
                ctrl_c.wbmux_sel = 2'b11;
            end
            OP_LDR: begin
                ctrl_c.addr1mux_sel  = 1'b1;
                ctrl_c.addr2mux_sel  = 2'b01;
                ctrl_c.lshf          = 1'b1;
                ctrl_c.dcacheR       = 1'b1;
                ctrl_c.dcache_enable = 1'b1;
                ctrl_c.wbmux_sel     = 2'b01;
                ctrl_c.load_reg      = 1'b1;
                ctrl_c.load_cc       = 1'b1;
            end
            OP_STR: begin
                ctrl_c.addr1mux_sel  = 1'b1;
                ctrl_c.addr2mux_sel  = 2'b01;
                ctrl_c.lshf          = 1'b1;
                ctrl_c.storemux_sel  = 1'b1;
                ctrl_c.dcacheW       = 1'b1;
                ctrl_c.aluop         = alu_passb;
                ctrl_c.dcache_enable = 1'b1;
            end
            OP_BR: begin
                ctrl_c.addr2mux_sel = 2'b10;
                ctrl_c.lshf         = 1'b1;
                ctrl_c.br_op        = 1'b1;
            end
`ifdef LC3B_INDIRECT_EN
            OP_LDI, OP_STI: begin
                ctrl_c.dcache_enable = 1'b1;
                if (uop != UOP_IND2) begin
                    // first access fetches the pointer: LDR addressing, no writeback
                    ctrl_c.addr1mux_sel = 1'b1;
                    ctrl_c.addr2mux_sel = 2'b01;
                    ctrl_c.lshf         = 1'b1;
                    ctrl_c.dcacheR      = 1'b1;
                end else if (opcode == OP_LDI) begin
                    ctrl_c.dcacheR   = 1'b1;
                    ctrl_c.wbmux_sel = 2'b01;
                    ctrl_c.load_reg  = 1'b1;
                    ctrl_c.load_cc   = 1'b1;
                end else begin
                    ctrl_c.addr1mux_sel = 1'b1;
                    ctrl_c.lshf         = 1'b1;
                    ctrl_c.storemux_sel = 1'b1;
                    ctrl_c.dcacheW      = 1'b1;
                    ctrl_c.aluop        = alu_passb;
                end
            end
`endif
            default: ;
        endcase
        if (OP_ILLEGAL_MASK[opcode]) begin
            ctrl_c         = '0;
            ctrl_c.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/lc3b_decode_seq.sv
// Registered, stallable LC-3b decode stage with flush, illegal-opcode
// flagging and an LDI/STI two-micro-op sequencer.
// Ports: clk, reset (async, active-high), bus (lc3b_decode_seq_if.slave).
// Parameters: WORD_W, ILLEGAL_FLAG (1: flag illegal ops, 0: drop as bubbles).
// Macro LC3B_INDIRECT_EN enables the IND2 state; otherwise out_uop stays 0.
module lc3b_decode_seq
    import lc3b_decode_seq_pkg::*;
#(
    parameter int unsigned WORD_W       = 16,
    parameter bit          ILLEGAL_FLAG = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    lc3b_decode_seq_if.slave     bus
);

    localparam int unsigned OPC_LSB = WORD_W - 4;

    logic             ind2;
    logic             advance;
    logic             accept;
    lc3b_opcode       dec_op;
    logic             dec_ir5;
    logic             dec_uop;
    lc3b_control_word dec_ctrl_c;
    lc3b_control_word load_ctrl_c;

`ifdef LC3B_INDIRECT_EN
    lc3b_decode_state_t state;
    assign ind2 = (state == IND2);
`else
    assign ind2 = 1'b0;
`endif

    // Output register may load when it is empty or being taken downstream.
    assign advance      = !bus.out_valid || !bus.stall;
    assign bus.in_ready = !ind2 && advance && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    // The second micro-op re-decodes the instruction held in out_ir.
    assign dec_op  = ind2 ? lc3b_opcode'(bus.out_ir[OPC_LSB +: 4]) : lc3b_opcode'(bus.in_ir[OPC_LSB +: 4]);
    assign dec_ir5 = ind2 ? bus.out_ir[5] : bus.in_ir[5];
    assign dec_uop = ind2 ? UOP_IND2 : 1'b0;

    lc3b_decode_comb u_comb (
        .opcode (dec_op),
        .ir5    (dec_ir5),
        .uop    (dec_uop),
        .ctrl_c (dec_ctrl_c)
    );

    // Attach the PC; undecodable words go out as an all-zero control word.
    always_comb begin
        load_ctrl_c    = dec_ctrl_c;
        load_ctrl_c.pc = ind2 ? CTRL_PC_W'(bus.out_pc) : CTRL_PC_W'(bus.in_pc);
        if (dec_ctrl_c.illegal) begin
            load_ctrl_c = '0;
        end
    end

    // Sequencer and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_ctrl    <= '0;
            bus.out_ir      <= '0;
            bus.out_pc      <= '0;
            bus.out_uop     <= 1'b0;
            bus.out_illegal <= 1'b0;
`ifdef LC3B_INDIRECT_EN
            state           <= IDLE;
`endif
        end else if (bus.flush) begin
            bus.out_valid   <= 1'b0;
            bus.out_uop     <= 1'b0;
            bus.out_illegal <= 1'b0;
`ifdef LC3B_INDIRECT_EN
            state           <= IDLE;
        end else if (state == IND2) begin
            if (advance) begin
                bus.out_ctrl    <= load_ctrl_c;
                bus.out_uop     <= UOP_IND2;
                bus.out_valid   <= 1'b1;
                bus.out_illegal <= 1'b0;
                state           <= IDLE;
            end
`endif
        end else if (accept) begin
            bus.out_ctrl    <= load_ctrl_c;
            bus.out_ir      <= bus.in_ir;
            bus.out_pc      <= bus.in_pc;
            bus.out_uop     <= 1'b0;
            bus.out_illegal <= dec_ctrl_c.illegal && ILLEGAL_FLAG;
            bus.out_valid   <= !dec_ctrl_c.illegal || ILLEGAL_FLAG;
`ifdef LC3B_INDIRECT_EN
            if (is_indirect(dec_op) && !dec_ctrl_c.illegal) begin
                state <= IND2;
            end
`endif
        end else if (advance) begin
            bus.out_valid   <= 1'b0;
            bus.out_uop     <= 1'b0;
            bus.out_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3b_decode_seq.sv
// Scoreboard bench for lc3b_decode_seq: a directed opening sequence, then
// randomized instructions with random stall/flush and an async reset pulse.
// Honors LC3B_INDIRECT_EN the same way as the design.
module tb_lc3b_decode_seq;
    import lc3b_decode_seq_pkg::*;

    localparam bit ILLEGAL_FLAG = 1'b1;
`ifdef LC3B_INDIRECT_EN
    localparam bit INDIRECT_EN = 1'b1;
`else
    localparam bit INDIRECT_EN = 1'b0;
`endif
    localparam int NCYC = 600;
    localparam int NDIR = 17;
    localparam int RST_CYC = 302;

    typedef struct packed {
        lc3b_control_word ctrl;
        logic [15:0]      ir;
        logic [15:0]      pc;
        logic             uop;
        logic             illegal;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    bit   run = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    lc3b_decode_seq_if #(.WORD_W(16)) bus ();

    lc3b_decode_seq #(.WORD_W(16), .ILLEGAL_FLAG(ILLEGAL_FLAG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    // Directed opening: ADD, LDR under 3-cycle stall, LDI, STI flushed in IND2, misc.
    logic        dir_v  [NDIR] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    logic [15:0] dir_ir [NDIR] = '{16'h12A3, 16'h6283, 16'h1042, 16'h1042, 16'h1042, 16'h1042,
                                   16'hA200, 16'h1263, 16'h1263, 16'hB441, 16'h1042, 16'h5260,
                                   16'h927F, 16'h0E05, 16'hF025, 16'h7283, 16'h0000};
    logic        dir_st [NDIR] = '{0,0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
    logic        dir_fl [NDIR] = '{0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the instruction semantics.
    function automatic lc3b_control_word model_ctrl(input logic [3:0] op, input logic ir5,
                                                    input logic uop, output logic legal);
        lc3b_control_word c;
        logic ind;
        ind   = INDIRECT_EN && (op == 4'hA || op == 4'hB);
        c     = '0;
        c.aluop = alu_passa;
        legal = 1'b1;
        if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
            c.aluop      = (op == 4'h1) ? alu_add : (op == 4'h5) ? alu_and : alu_not;
            c.load_reg   = 1'b1;
            c.load_cc    = 1'b1;
            c.wbmux_sel  = 2'b11;
            c.sr2mux_sel = (op != 4'h9) && ir5;
        end else if (op == 4'h6 || op == 4'h7 || (ind && !uop) || (ind && op == 4'hB)) begin
            // base + (offset << 1) memory access
            c.addr1mux_sel  = 1'b1;
            c.addr2mux_sel  = (ind && uop) ? 2'b00 : 2'b01;
            c.lshf          = 1'b1;
            c.dcache_enable = 1'b1;
            if (op == 4'h7 || (op == 4'hB && uop)) begin
                c.storemux_sel = 1'b1;
                c.dcacheW      = 1'b1;
                c.aluop        = alu_passb;
            end else begin
                c.dcacheR = 1'b1;
            end
            if (op == 4'h6) begin
                c.wbmux_sel = 2'b01;
                c.load_reg  = 1'b1;
                c.load_cc   = 1'b1;
            end
        end else if (ind) begin
            // LDI second access loads the register from memory
            c.dcacheR       = 1'b1;
            c.dcache_enable = 1'b1;
            c.wbmux_sel     = 2'b01;
            c.load_reg      = 1'b1;
            c.load_cc       = 1'b1;
        end else if (op == 4'h0) begin
            c.addr2mux_sel = 2'b10;
            c.lshf         = 1'b1;
            c.br_op        = 1'b1;
        end else begin
            legal = 1'b0;
        end
        c.uop = uop;
        if (!legal) c = '0;
        return c;
    endfunction

    // Monitor: compare the presented output with the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (run) begin
            exp_t act;
            #2;
            chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
            if (q.size() > 0 && bus.out_valid) begin
                act.ctrl    = bus.out_ctrl;
                act.ir      = bus.out_ir;
                act.pc      = bus.out_pc;
                act.uop     = bus.out_uop;
                act.illegal = bus.out_illegal;
                chk("out_word", 128'(act), 128'(q[0]));
            end
            if (q.size() > 0 && !bus.stall && !bus.flush) void'(q.pop_front());
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},   128'(bus.out_valid),   128'(0));
        chk({tag, "_ctrl"},    128'(bus.out_ctrl),    128'(0));
        chk({tag, "_ir"},      128'(bus.out_ir),      128'(0));
        chk({tag, "_pc"},      128'(bus.out_pc),      128'(0));
        chk({tag, "_uop"},     128'(bus.out_uop),     128'(0));
        chk({tag, "_illegal"}, 128'(bus.out_illegal), 128'(0));
    endtask

    // Driver: applies stimulus, checks in_ready, stages expected micro-ops.
    initial begin
        exp_t stage[$];
        logic exp_ready;
        logic legal;
        lc3b_control_word c;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ir    = '0;
        bus.in_pc    = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", 128'(bus.in_ready), 128'(1));
        run = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc < NDIR) begin
                bus.in_valid = dir_v[cyc];
                bus.in_ir    = dir_ir[cyc];
                bus.in_pc    = 16'h3000 + 16'(2 * cyc);
                bus.stall    = dir_st[cyc];
                bus.flush    = dir_fl[cyc];
            end else if (cyc >= NCYC - 10) begin
                bus.in_valid = 1'b0;
                bus.stall    = 1'b0;
                bus.flush    = 1'b0;
            end else begin
                logic [15:0] ir;
                ir = 16'($urandom);
                if ($urandom_range(0, 3) == 0) ir[15:12] = {3'b101, 1'($urandom)};
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_ir    = ir;
                bus.in_pc    = 16'($urandom);
                bus.stall    = ($urandom_range(0, 3) == 0);
                bus.flush    = ($urandom_range(0, 19) == 0);
                if (cyc >= RST_CYC - 2 && cyc <= RST_CYC) begin
                    bus.in_valid = 1'b1;
                    bus.stall    = 1'b1;
                    bus.flush    = 1'b0;
                end
            end
            #1;
            // Output holds at most one item plus a pending second micro-op.
            exp_ready = !bus.flush && (q.size() == 0 || (q.size() == 1 && !bus.stall));
            chk("in_ready", 128'(bus.in_ready), 128'(exp_ready));
            stage.delete();
            if (bus.in_valid && exp_ready) begin
                exp_t e;
                c = model_ctrl(bus.in_ir[15:12], bus.in_ir[5], 1'b0, legal);
                e.ir      = bus.in_ir;
                e.pc      = bus.in_pc;
                e.uop     = 1'b0;
                e.illegal = !legal;
                e.ctrl    = c;
                if (legal) e.ctrl.pc = bus.in_pc;
                if (legal || ILLEGAL_FLAG) stage.push_back(e);
                if (legal && INDIRECT_EN && (bus.in_ir[15:12] == 4'hA || bus.in_ir[15:12] == 4'hB)) begin
                    e.ctrl    = model_ctrl(bus.in_ir[15:12], bus.in_ir[5], 1'b1, legal);
                    e.ctrl.pc = bus.in_pc;
                    e.uop     = 1'b1;
                    stage.push_back(e);
                end
            end
            if (cyc == RST_CYC) begin
                // async reset between edges while the output is stalled
                #2;
                reset = 1'b1;
                #1;
                chk_reset_outputs("async_reset");
                bus.in_valid = 1'b0;
                bus.flush    = 1'b0;
                reset        = 1'b0;
                #1;
                chk("in_ready_after_async_reset", 128'(bus.in_ready), 128'(1));
                q.delete();
                stage.delete();
            end
            @(posedge clk);
            if (bus.flush) q.delete();
            else foreach (stage[i]) q.push_back(stage[i]);
        end

        @(negedge clk);
        #3;
        chk("drain", 128'(q.size()), 128'(0));
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
